// File: rtl/hs_ram_bridge.sv
// hs_ram_bridge: hands the CPU work-RAM port to the hiscore engine on request.
// The CPU is stalled at a bus-cycle boundary, or after a bounded drain timeout,
// before the engine is granted. Engine reads have a fixed 3-clock latency.
//
// state   | meaning
// --------+-----------------------------------------------------------
// CPU_OWN | CPU drives RAM, no stall
// DRAIN   | stall requested, waiting for cpu_ce or drain timeout
// HS_OWN  | engine owns RAM through its registered inputs
// RELEASE | one dead clock with no writes before handing back to CPU
module hs_ram_bridge #(
    parameter logic [15:0] RAM_BASE  = 16'hE000,
    parameter int          RAM_AW    = 11,
    parameter logic [7:0]  DRAIN_MAX = 8'd255
) (
    input  logic              clk48M,
    input  logic              reset_n,
    input  logic              hs_access,
    input  logic [15:0]       hs_address,
    input  logic [7:0]        hs_data_in,
    input  logic              hs_write,
    output logic [7:0]        hs_data_out,
    output logic              hs_grant,
    output logic              cpu_hold,
    input  logic              cpu_ce,
    input  logic              cpu_cs,
    input  logic              cpu_wr,
    input  logic [15:0]       cpu_ad,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wd,
    input  logic [7:0]        ram_rd
);

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        DRAIN   = 2'd1,
        HS_OWN  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [16:0] WIN_SIZE = 17'd1 << RAM_AW;

    state_t            state;
    logic [7:0]        drain_cnt;
    logic [15:0]       hs_addr_q;
    logic [7:0]        hs_din_q;
    logic              hs_we_q;
    logic              win_q;
    logic [16:0]       hs_off;
    logic              hs_in_win;
    logic [RAM_AW-1:0] cpu_off;

    // 17-bit subtraction: addresses below RAM_BASE borrow into bit 16 and fall outside the window
    assign hs_off    = {1'b0, hs_addr_q} - {1'b0, RAM_BASE};
    assign hs_in_win = (hs_off < WIN_SIZE);
    assign cpu_off   = cpu_ad[RAM_AW-1:0] - RAM_BASE[RAM_AW-1:0];
    assign cpu_din   = ram_rd;

    // ownership state machine with registered stall/grant outputs
    always_ff @(posedge clk48M or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CPU_OWN;
            drain_cnt <= 8'd0;
            cpu_hold  <= 1'b0;
            hs_grant  <= 1'b0;
        end else begin
            case (state)
                CPU_OWN: begin
                    if (hs_access) begin
                        state     <= DRAIN;
                        drain_cnt <= 8'd0;
                        cpu_hold  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!hs_access) begin
                        state    <= CPU_OWN;
                        cpu_hold <= 1'b0;
                    end else if (cpu_ce || (drain_cnt == DRAIN_MAX)) begin
                        state    <= HS_OWN;
                        hs_grant <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 8'd1;
                    end
                end
                HS_OWN: begin
                    if (!hs_access) begin
                        state    <= RELEASE;
                        hs_grant <= 1'b0;
                    end
                end
                RELEASE: begin
                    state    <= CPU_OWN;
                    cpu_hold <= 1'b0;
                end
                default: begin
                    state    <= CPU_OWN;
                    cpu_hold <= 1'b0;
                    hs_grant <= 1'b0;
                end
            endcase
        end
    end

    // engine input register and read-data pipeline; strobes outside HS_OWN never reach the RAM
    always_ff @(posedge clk48M or negedge reset_n) begin
        if (!reset_n) begin
            hs_addr_q   <= 16'd0;
            hs_din_q    <= 8'd0;
            hs_we_q     <= 1'b0;
            win_q       <= 1'b0;
            hs_data_out <= 8'h00;
        end else begin
            hs_addr_q <= hs_address;
            hs_din_q  <= hs_data_in;
            hs_we_q   <= hs_write && (state == HS_OWN);
            win_q     <= hs_in_win;
            if (state == HS_OWN) begin
                hs_data_out <= win_q ? ram_rd : 8'hFF;
            end
        end
    end

    // RAM port mux; RELEASE keeps the engine address but blocks every write
    always_comb begin
        ram_addr = cpu_off;
        ram_we   = cpu_cs & cpu_wr;
        ram_wd   = cpu_dout;
        if (state == HS_OWN) begin
            ram_addr = hs_off[RAM_AW-1:0];
            ram_we   = hs_we_q & hs_in_win;
            ram_wd   = hs_din_q;
        end else if (state == RELEASE) begin
            ram_addr = hs_off[RAM_AW-1:0];
            ram_we   = 1'b0;
            ram_wd   = hs_din_q;
        end
    end

endmodule

// File: tb/tb_hs_ram_bridge.sv
// Bench for hs_ram_bridge: a synchronous RAM model on the RAM port and a
// byte-array reference of what the RAM must contain after CPU and engine traffic.
module tb_hs_ram_bridge;

    logic        clk48M = 1'b0;
    logic        reset_n = 1'b0;
    logic        hs_access = 1'b0;
    logic [15:0] hs_address = 16'd0;
    logic [7:0]  hs_data_in = 8'd0;
    logic        hs_write = 1'b0;
    logic [7:0]  hs_data_out;
    logic        hs_grant;
    logic        cpu_hold;
    logic        cpu_ce = 1'b0;
    logic        cpu_cs = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [15:0] cpu_ad = 16'd0;
    logic [7:0]  cpu_dout = 8'd0;
    logic [7:0]  cpu_din;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wd;
    logic [7:0]  ram_rd = 8'd0;

    logic [7:0]  mem [0:2047];
    logic [7:0]  exp_mem [0:2047];
    int          we_count = 0;
    logic [10:0] last_addr = 11'd0;
    logic [7:0]  last_data = 8'd0;
    int          tests_run = 0;
    int          tests_failed = 0;

    hs_ram_bridge dut (
        .clk48M(clk48M), .reset_n(reset_n),
        .hs_access(hs_access), .hs_address(hs_address), .hs_data_in(hs_data_in),
        .hs_write(hs_write), .hs_data_out(hs_data_out), .hs_grant(hs_grant),
        .cpu_hold(cpu_hold), .cpu_ce(cpu_ce), .cpu_cs(cpu_cs), .cpu_wr(cpu_wr),
        .cpu_ad(cpu_ad), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wd(ram_wd), .ram_rd(ram_rd)
    );

    always #5 clk48M = ~clk48M;

    // synchronous read-first RAM
    always @(posedge clk48M) begin
        if (ram_we) mem[ram_addr] <= ram_wd;
        ram_rd <= mem[ram_addr];
    end

    // write-pulse monitor
    always @(posedge clk48M) begin
        if (ram_we) begin
            we_count  <= we_count + 1;
            last_addr <= ram_addr;
            last_data <= ram_wd;
        end
    end

    task automatic step();
        @(posedge clk48M);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_cs = 1'b0;
        cpu_wr = 1'b0;
        cpu_ce = 1'b0;
    endtask

    // CPU write issued while the bench knows the CPU owns the RAM
    task automatic cpu_write(input logic [10:0] off, input logic [7:0] d);
        cpu_cs   = 1'b1;
        cpu_wr   = 1'b1;
        cpu_ad   = 16'hE000 + {5'd0, off};
        cpu_dout = d;
        exp_mem[off] = d;
        step();
        cpu_cs = 1'b0;
        cpu_wr = 1'b0;
    endtask

    // raise hs_access and wait (bounded) for the grant
    task automatic acquire(input bit rand_ce, output bit ok);
        cpu_idle();
        hs_access = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (hs_grant) begin
                ok = 1'b1;
                break;
            end
            cpu_ce = rand_ce ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        cpu_ce = 1'b0;
    endtask

    task automatic drop_access();
        hs_access = 1'b0;
        hs_write  = 1'b0;
        step();
        step();
    endtask

    function automatic logic [15:0] rand_out_of_window();
        case ($urandom_range(0, 2))
            0:       return 16'hD000 + 16'($urandom_range(0, 16'h0FFF));
            1:       return 16'hE800 + 16'($urandom_range(0, 16'h17FF));
            default: return 16'($urandom_range(0, 16'hDFFF));
        endcase
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        cpu_idle();
        step(); step(); step();
        tests_run++;
        if (cpu_hold !== 1'b0 || hs_grant !== 1'b0 || hs_data_out !== 8'h00 || ram_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: hold=%b grant=%b dout=%h we=%b required 0 0 00 0",
                     cpu_hold, hs_grant, hs_data_out, ram_we);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic init_ram();
        for (int i = 0; i < 2048; i++) cpu_write(11'(i), 8'($urandom));
        cpu_write(11'h012, 8'h5A);
    endtask

    task automatic test_grant_ce();
        hs_access = 1'b1;
        for (int k = 1; k <= 5; k++) step();
        tests_run++;
        if (hs_grant !== 1'b0) begin
            tests_failed++;
            $display("FAIL grant_ce_early: grant=%b required 0 at clock 5", hs_grant);
        end
        cpu_ce = 1'b1;
        step();
        cpu_ce = 1'b0;
        tests_run++;
        if (hs_grant !== 1'b1 || cpu_hold !== 1'b1) begin
            tests_failed++;
            $display("FAIL grant_ce: grant=%b hold=%b required 1 1 at clock 6", hs_grant, cpu_hold);
        end
        hs_access = 1'b0;
        step();
        tests_run++;
        if (hs_grant !== 1'b0 || cpu_hold !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_1: grant=%b hold=%b required 0 1", hs_grant, cpu_hold);
        end
        step();
        tests_run++;
        if (cpu_hold !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_2: hold=%b required 0", cpu_hold);
        end
    endtask

    task automatic test_grant_min();
        hs_access = 1'b1;
        cpu_ce = 1'b1;
        step();
        tests_run++;
        if (hs_grant !== 1'b0) begin
            tests_failed++;
            $display("FAIL grant_min_early: grant=%b required 0 at clock 1", hs_grant);
        end
        step();
        cpu_ce = 1'b0;
        tests_run++;
        if (hs_grant !== 1'b1) begin
            tests_failed++;
            $display("FAIL grant_min: grant=%b required 1 at clock 2", hs_grant);
        end
        drop_access();
    endtask

    task automatic test_grant_max();
        int first;
        first = -1;
        cpu_idle();
        hs_access = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            step();
            if (hs_grant && first < 0) first = k;
        end
        tests_run++;
        if (first != 257) begin
            tests_failed++;
            $display("FAIL grant_timeout: grant at clock %0d required 257", first);
        end
        drop_access();
    endtask

    task automatic test_read();
        bit ok;
        acquire(1'b0, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL read_grant: grant=%b required 1", hs_grant);
        end
        hs_address = 16'hD000;
        step(); step(); step();
        tests_run++;
        if (hs_data_out !== 8'hFF) begin
            tests_failed++;
            $display("FAIL read_outside: got %h required FF", hs_data_out);
        end
        hs_address = 16'hE012;
        step(); step();
        tests_run++;
        if (hs_data_out !== 8'hFF) begin
            tests_failed++;
            $display("FAIL read_latency_early: got %h required FF after 2 clocks", hs_data_out);
        end
        step();
        tests_run++;
        if (hs_data_out !== 8'h5A) begin
            tests_failed++;
            $display("FAIL read_latency: got %h required 5A after 3 clocks", hs_data_out);
        end
        drop_access();
        tests_run++;
        if (hs_data_out !== 8'h5A) begin
            tests_failed++;
            $display("FAIL dout_hold: got %h required 5A", hs_data_out);
        end
    endtask

    task automatic test_write();
        bit ok;
        int c0;
        acquire(1'b1, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL write_grant: grant=%b required 1", hs_grant);
        end
        c0 = we_count;
        hs_address = 16'hE7FF;
        hs_data_in = 8'hA5;
        hs_write = 1'b1;
        step();
        hs_write = 1'b0;
        tests_run++;
        if (ram_we !== 1'b1 || ram_addr !== 11'h7FF || ram_wd !== 8'hA5) begin
            tests_failed++;
            $display("FAIL write_pulse: we=%b addr=%h data=%h required 1 7ff a5", ram_we, ram_addr, ram_wd);
        end
        exp_mem[11'h7FF] = 8'hA5;
        step(); step();
        tests_run++;
        if (we_count - c0 != 1 || last_addr !== 11'h7FF || last_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL write_once: pulses=%0d addr=%h data=%h required 1 7ff a5",
                     we_count - c0, last_addr, last_data);
        end
        c0 = we_count;
        hs_address = 16'hE800;
        hs_data_in = 8'h3C;
        hs_write = 1'b1;
        step();
        hs_write = 1'b0;
        step(); step();
        tests_run++;
        if (we_count - c0 != 0) begin
            tests_failed++;
            $display("FAIL write_outside: pulses=%0d required 0", we_count - c0);
        end
        drop_access();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int c0;
        acquire(1'b1, ok);
        hs_address = 16'hE012;
        step(); step(); step();
        hs_address = 16'hE050;
        hs_data_in = ~exp_mem[11'h050];
        hs_write = 1'b1;
        step();
        #1 reset_n = 1'b0;
        #1;
        tests_run++;
        if (!ok || cpu_hold !== 1'b0 || hs_grant !== 1'b0 || hs_data_out !== 8'h00 || ram_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: granted=%b hold=%b grant=%b dout=%h we=%b required 1 0 0 00 0",
                     ok, cpu_hold, hs_grant, hs_data_out, ram_we);
        end
        c0 = we_count;
        hs_write = 1'b0;
        hs_access = 1'b0;
        step(); step();
        reset_n = 1'b1;
        step(); step(); step(); step();
        tests_run++;
        if (we_count != c0 || mem[11'h050] !== exp_mem[11'h050]) begin
            tests_failed++;
            $display("FAIL reset_discard: pulses=%0d ram=%h required 0 %h",
                     we_count - c0, mem[11'h050], exp_mem[11'h050]);
        end
    endtask

    task automatic test_abort();
        bit ok;
        bit saw_grant;
        saw_grant = 1'b0;
        cpu_idle();
        hs_access = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (hs_grant) saw_grant = 1'b1;
        end
        hs_access = 1'b0;
        step();
        if (hs_grant) saw_grant = 1'b1;
        tests_run++;
        if (cpu_hold !== 1'b0 || saw_grant) begin
            tests_failed++;
            $display("FAIL abort: hold=%b saw_grant=%b required 0 0", cpu_hold, saw_grant);
        end
        acquire(1'b1, ok);
        hs_access = 1'b0;
        step();
        cpu_cs = 1'b1;
        cpu_wr = 1'b1;
        cpu_ad = 16'hE100;
        cpu_dout = ~exp_mem[11'h100];
        #1;
        tests_run++;
        if (!ok || ram_we !== 1'b0 || cpu_hold !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_cpu_wr: granted=%b we=%b hold=%b required 1 0 1", ok, ram_we, cpu_hold);
        end
        step();
        cpu_idle();
        step();
        tests_run++;
        if (mem[11'h100] !== exp_mem[11'h100]) begin
            tests_failed++;
            $display("FAIL release_ram: ram=%h required %h", mem[11'h100], exp_mem[11'h100]);
        end
    endtask

    task automatic test_handover();
        bit ok;
        int c0;
        int exp_writes;
        int bad_reads;
        int bad_mem;
        logic [10:0] off;
        logic [15:0] a;
        logic [7:0] d;
        logic [7:0] e;
        c0 = we_count;
        exp_writes = 0;
        bad_reads = 0;
        for (int s = 0; s < 100; s++) begin
            for (int t = 0; t < int'($urandom_range(0, 8)); t++) begin
                off = 11'($urandom);
                cpu_cs = 1'($urandom);
                cpu_wr = 1'($urandom);
                cpu_ad = 16'hE000 + {5'd0, off};
                cpu_dout = 8'($urandom);
                if (cpu_cs && cpu_wr) begin
                    exp_mem[off] = cpu_dout;
                    exp_writes++;
                end
                step();
            end
            acquire(1'b1, ok);
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("FAIL handover_grant: session %0d grant=%b required 1", s, hs_grant);
            end
            for (int op = 0; op < int'($urandom_range(1, 6)); op++) begin
                a = ($urandom_range(0, 7) == 0) ? rand_out_of_window()
                                                 : 16'hE000 + 16'($urandom_range(0, 2047));
                cpu_cs = 1'b1;
                cpu_wr = 1'b1;
                cpu_ad = 16'hE000 + 16'($urandom_range(0, 2047));
                cpu_dout = 8'($urandom);
                hs_address = a;
                if ($urandom_range(0, 1) == 0) begin
                    d = 8'($urandom);
                    hs_data_in = d;
                    hs_write = 1'b1;
                    step();
                    hs_write = 1'b0;
                    if (a >= 16'hE000 && a <= 16'hE7FF) begin
                        exp_mem[a - 16'hE000] = d;
                        exp_writes++;
                    end
                end else begin
                    step(); step(); step();
                    e = (a >= 16'hE000 && a <= 16'hE7FF) ? exp_mem[a - 16'hE000] : 8'hFF;
                    tests_run++;
                    if (hs_data_out !== e) begin
                        tests_failed++;
                        bad_reads++;
                        $display("FAIL handover_read: addr=%h got %h required %h", a, hs_data_out, e);
                    end
                end
            end
            drop_access();
            tests_run++;
            if (cpu_hold !== 1'b0) begin
                tests_failed++;
                $display("FAIL handover_release: session %0d hold=%b required 0", s, cpu_hold);
            end
            cpu_idle();
        end
        step(); step();
        tests_run++;
        if (we_count - c0 != exp_writes) begin
            tests_failed++;
            $display("FAIL handover_pulses: got %0d required %0d", we_count - c0, exp_writes);
        end
        bad_mem = 0;
        for (int i = 0; i < 2048; i++) begin
            if (mem[i] !== exp_mem[i]) begin
                if (bad_mem == 0)
                    $display("FAIL ram_scoreboard: addr %h got %h required %h", i[10:0], mem[i], exp_mem[i]);
                bad_mem++;
            end
        end
        tests_run++;
        if (bad_mem != 0) begin
            tests_failed++;
            $display("FAIL ram_scoreboard_total: %0d bytes differ, required 0", bad_mem);
        end
    endtask

    initial begin
        test_reset();
        init_ram();
        test_grant_ce();
        test_grant_min();
        test_grant_max();
        test_read();
        test_write();
        test_reset_mid();
        test_abort();
        test_handover();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hs_ram_bridge.md
# hs_ram_bridge

Responder for the hiscore engine's RAM-access port, instantiated inside the game core next to the CPU work RAM. On `hs_access`, it stalls the CPU at a clean bus-cycle boundary, hands the work-RAM port to the hiscore engine, and services its fixed-latency reads and single-cycle writes. When access drops, it returns the RAM to the CPU.

## Interface
Parameters:
- RAM_BASE, 16'hE000: CPU/hiscore address of work-RAM byte 0.
- RAM_AW, 11: work-RAM address width; window is RAM_BASE .. RAM_BASE+2^RAM_AW-1.
- DRAIN_MAX, 255: maximum clocks to wait for a CPU cycle boundary before forcing the grant.

Ports:
- clk48M  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- hs_access  in  1  hiscore engine requests RAM ownership (level).
- hs_address  in  16  hiscore byte address.
- hs_data_in  in  8  data to write to RAM.
- hs_write  in  1  write strobe; one byte per asserted clock.
- hs_data_out  out  8  read data for the engine.
- hs_grant  out  1  bridge owns the RAM for the engine.
- cpu_hold  out  1  stall request to the CPU clock enable.
- cpu_ce  in  1  CPU clock-enable pulse; marks a bus-cycle boundary.
- cpu_cs  in  1  CPU selects work RAM.
- cpu_wr  in  1  CPU write.
- cpu_ad  in  16  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_din  out  8  RAM read data to the CPU (equals ram_rd).
- ram_addr  out  RAM_AW  RAM port address.
- ram_we  out  1  RAM write enable.
- ram_wd  out  8  RAM write data.
- ram_rd  in  8  RAM read data; synchronous, valid 1 clock after ram_addr.

## Operation
- States: CPU_OWN, DRAIN, HS_OWN, RELEASE.
- **CPU_OWN**
  - RAM mux is combinational from the CPU: ram_addr = (cpu_ad - RAM_BASE)[RAM_AW-1:0], ram_we = cpu_cs & cpu_wr, ram_wd = cpu_dout.
  - Moves to DRAIN when hs_access=1.
- **DRAIN**
  - cpu_hold=1; CPU mux still active.
  - 8-bit drain counter starts at 0 and increments each clock.
  - Moves to HS_OWN on the first cpu_ce=1 seen in DRAIN, or when the counter reaches DRAIN_MAX.
  - If hs_access falls, returns to CPU_OWN next clock and cpu_hold drops.
- **HS_OWN**
  - cpu_hold=1, hs_grant=1.
  - RAM mux comes from the registered hiscore inputs (hs_address, hs_data_in, hs_write, each registered 1 clock).
  - In-window test: 0 <= hs_address - RAM_BASE < 2^RAM_AW, using 17-bit unsigned arithmetic, no wrap.
  - In window: ram_addr = offset; ram_we = registered hs_write; ram_wd = registered hs_data_in.
  - Out of window: ram_we=0; the read returns 8'hFF.
  - Moves to RELEASE when hs_access=0.
- **RELEASE**
  - One clock with hs_grant=0, cpu_hold=1, ram_we=0, so no hiscore write can overlap a CPU write. Then moves to CPU_OWN.
- hs_write while not in HS_OWN is ignored: no RAM write.
- cpu_wr while in HS_OWN or RELEASE is ignored.
- hs_data_out holds its last value outside HS_OWN.
- Reset (any time, including mid-transfer) forces:
  - state CPU_OWN;
  - cpu_hold=0, hs_grant=0, hs_data_out=8'h00;
  - registered hiscore inputs cleared, so ram_we follows the CPU mux only.
- A pending registered write is discarded on reset.

## Timing
- Grant latency is measured from the hs_access rising edge to hs_grant=1:
  - 2 clocks minimum (cpu_ce already high on the first DRAIN clock);
  - DRAIN_MAX+2 clocks maximum.
- Read latency in HS_OWN: hs_data_out reflects the hs_address sampled 3 clocks earlier (input register, RAM, output register).
  - The engine holds each address for at least 3 clocks after grant.
- Write: hs_write at clock N (address/data stable) gives ram_we=1 at clock N+1, for exactly one clock per strobe clock.
- Back-to-back hs_write clocks produce back-to-back RAM writes; there is no throughput limit.
- Release latency, hs_access falling edge to cpu_hold=0: 2 clocks (HS_OWN→RELEASE, RELEASE→CPU_OWN).
- hs_access toggling faster than the grant latency is legal; the state machine follows the current level.

## Test plan
- **Reset:** assert reset_n=0 mid-HS_OWN with hs_write=1 → cpu_hold=0, hs_grant=0, hs_data_out=00 immediately; no ram_we pulse after release.
- **Grant/drain:** raise hs_access, pulse cpu_ce on the 5th clock → hs_grant=1 on clock 6; with cpu_ce held 0 and DRAIN_MAX=255 → hs_grant rises exactly 257 clocks after hs_access.
- **Read latency:** preload RAM[0x012]=0x5A, grant, drive hs_address=E012 → hs_data_out=5A exactly 3 clocks later; hs_address=D000 → FF.
- **Write:** in HS_OWN, hs_address=E7FF, hs_data_in=A5, hs_write for 1 clock → one ram_we pulse at offset 7FF, data A5.
  - hs_address=E800 → no ram_we.
- **Abort:** drop hs_access during DRAIN → hs_grant never asserts, cpu_hold=0 next clock.
  - CPU write at cpu_ad=E100 during RELEASE → no RAM write.
- **Handover:** random CPU traffic plus 100 interleaved hiscore sessions → RAM scoreboard matches, and ram_we is never asserted by both sources in one clock.
